// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential single-precision adder/subtractor.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;      // hidden bit included, zero for exp==0
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  function automatic logic [31:0] inf_of(input logic sign);
    return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Request/response handshake bundle between a producer and fp_addsub_seq.
interface fp_addsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        checkequation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, A, B, checkequation, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, A, B, checkequation, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_unpack.sv
// Field extraction and zero/inf/NaN classification of one IEEE754 single.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]  value,
  output fp_unpacked_t op
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  always_comb begin
    exp_f      = value[30:23];
    frac_f     = value[22:0];
    op.sign    = value[31];
    op.exp     = exp_f;
    op.is_zero = (exp_f == '0);
    op.is_inf  = (exp_f == '1) && (frac_f == '0);
    op.is_nan  = (exp_f == '1) && (frac_f != '0);
    op.man     = op.is_zero ? '0 : {1'b1, frac_f};
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE754 single-precision add/subtract with valid/ready handshake.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_addsub_seq
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp_addsub_seq_if.slave bus
);

  localparam int unsigned ALIGN_CAP = 26;

  state_t       state;
  logic [31:0]  a_raw, b_raw;
  logic         sub_r;
  logic         sign_a, sign_b;
  logic [9:0]   exp_r;
  logic [7:0]   exp_b;
  logic [27:0]  man_a, man_b;   // {carry, hidden, frac[22:0], guard, round, sticky}
  logic [4:0]   shift_cnt;

  fp_unpacked_t ua, ub;
  logic         sb_eff, b_bigger, special;
  logic [31:0]  special_res;
  logic [27:0]  sum_c;
  logic [22:0]  rnd_frac;
  logic [9:0]   rnd_exp;

  fp_unpack u_unpack_a (.value(a_raw), .op(ua));
  fp_unpack u_unpack_b (.value(b_raw), .op(ub));

  always_comb begin
    sb_eff      = ub.sign ^ sub_r;
    b_bigger    = {ub.exp, ub.man} > {ua.exp, ua.man};
    special     = 1'b1;
    special_res = '0;
    if (ua.is_nan || ub.is_nan)
      special_res = QNAN;
    else if (ua.is_inf && ub.is_inf)
      special_res = (ua.sign != sb_eff) ? QNAN : inf_of(ua.sign);
    else if (ua.is_inf)
      special_res = inf_of(ua.sign);
    else if (ub.is_inf)
      special_res = inf_of(sb_eff);
    // exact cancellation and 0+0 resolve here so zero results share the special-case latency
    else if (({ua.exp, ua.man} == {ub.exp, ub.man}) &&
             ((ua.sign != sb_eff) || (ua.is_zero && ub.is_zero)))
      special_res = '0;
    else
      special = 1'b0;
  end

  always_comb begin
    sum_c = (sign_a == sign_b) ? (man_a + man_b) : (man_a - man_b);
  end

`ifdef ROUND_NEAREST_EN
  logic        rnd_inc;
  logic [24:0] rnd_sum;
  always_comb begin
    rnd_inc = man_a[2] & (man_a[1] | man_a[0] | man_a[3]);
    rnd_sum = {1'b0, man_a[26:3]} + 25'(rnd_inc);
    if (rnd_sum[24]) begin
      rnd_frac = rnd_sum[23:1];
      rnd_exp  = exp_r + 10'd1;
    end else begin
      rnd_frac = rnd_sum[22:0];
      rnd_exp  = exp_r;
    end
  end
`else
  always_comb begin
    rnd_frac = man_a[25:3];
    rnd_exp  = exp_r;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      a_raw         <= '0;
      b_raw         <= '0;
      sub_r         <= 1'b0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      exp_r         <= '0;
      exp_b         <= '0;
      man_a         <= '0;
      man_b         <= '0;
      shift_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_raw        <= bus.A;
            b_raw        <= bus.B;
            sub_r        <= bus.checkequation;
            bus.in_ready <= 1'b0;
            state        <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (special) begin
            bus.result    <= special_res;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            sign_a    <= b_bigger ? sb_eff : ua.sign;
            sign_b    <= b_bigger ? ua.sign : sb_eff;
            exp_r     <= {2'b00, (b_bigger ? ub.exp : ua.exp)};
            exp_b     <= b_bigger ? ua.exp : ub.exp;
            man_a     <= {1'b0, (b_bigger ? ub.man : ua.man), 3'b000};
            man_b     <= {1'b0, (b_bigger ? ua.man : ub.man), 3'b000};
            shift_cnt <= '0;
            state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if ((exp_b == exp_r[7:0]) || (shift_cnt == 5'(ALIGN_CAP))) begin
            state <= S_ADD;
          end else begin
            man_b     <= {1'b0, man_b[27:2], man_b[1] | man_b[0]};
            exp_b     <= exp_b + 8'd1;
            shift_cnt <= shift_cnt + 5'd1;
          end
        end
        S_ADD: begin
          if (sum_c == '0) begin
            bus.result    <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            man_a <= sum_c;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (man_a[27]) begin
            man_a <= {1'b0, man_a[27:2], man_a[1] | man_a[0]};
            exp_r <= exp_r + 10'd1;
            state <= S_ROUND;
          end else if (man_a[26] || (exp_r == 10'd1)) begin
            state <= S_ROUND;
          end else begin
            man_a <= {man_a[26:0], 1'b0};
            exp_r <= exp_r - 10'd1;
          end
        end
        S_ROUND: begin
          // hidden bit still clear means normalization stopped at exp 1: below normal range
          if (!man_a[26]) begin
            bus.result    <= {sign_a, 31'b0};
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b1;
          end else if (rnd_exp >= 10'(EXP_MAX)) begin
            bus.result    <= inf_of(sign_a);
            bus.overflow  <= 1'b1;
            bus.underflow <= 1'b0;
          end else begin
            bus.result    <= {sign_a, rnd_exp[7:0], rnd_frac};
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
          end
          bus.out_valid <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq with hand-computed IEEE754 results.
module tb_fp_addsub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_seq_if bus ();

  fp_addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clk);
    bus.A             = a;
    bus.B             = b;
    bus.checkequation = sub;
    bus.in_valid      = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency counts cycles inclusively: the accept cycle is cycle 1.
  task automatic wait_out(output int lat);
    lat = 2;
    while (!bus.out_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // exp_lat == 0 means only the 60-cycle bound applies
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic [31:0] exp_res,
                     input logic exp_ovf, input logic exp_unf, input int exp_lat);
    int lat;
    issue(a, b, sub);
    wait_out(lat);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " flags"}, {30'b0, bus.overflow, bus.underflow}, {30'b0, exp_ovf, exp_unf});
    if (exp_lat != 0) chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    else              chk({tag, " latency<=60"}, 32'(lat <= 60), 32'd1);
    release_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen;
    logic [31:0] rnd_expect;

    bus.in_valid      = 1'b0;
    bus.A             = '0;
    bus.B             = '0;
    bus.checkequation = 1'b0;
    bus.out_ready     = 1'b0;
    rst               = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result",    bus.result,         32'h0);
    chk("reset overflow",  32'(bus.overflow),  32'd0);
    chk("reset underflow", 32'(bus.underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("half_plus_half", 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0);
    run("half_minus",     32'h3F000000, 32'h3EE00000, 1'b1, 32'h3D800000, 1'b0, 1'b0, 0);
    run("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 0);
    run("tiny_diff",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 0);
    run("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 3);
    run("one_plus_two",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 0);
    run("neg_add",        32'hBFC00000, 32'hBFC00000, 1'b0, 32'hC0400000, 1'b0, 1'b0, 0);
    run("swap_sub",       32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 0);
    run("zero_plus_five", 32'h00000000, 32'h40A00000, 1'b0, 32'h40A00000, 1'b0, 1'b0, 0);
    run("nan_in",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 3);
    run("inf_pass",       32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 3);
    run("one_minus_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 3);

`ifdef ROUND_NEAREST_EN
    rnd_expect = 32'h3F800002;
`else
    rnd_expect = 32'h3F800001;
`endif
    run("round_tie_odd",  32'h3F800001, 32'h33800000, 1'b0, rnd_expect, 1'b0, 1'b0, 0);

    // inf - inf, then hold the result with out_ready low
    issue(32'h7F800000, 32'h7F800000, 1'b1);
    wait_out(lat);
    chk("inf_minus_inf latency", 32'(lat), 32'd3);
    chk("inf_minus_inf result", bus.result, 32'h7FC00000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold result", bus.result, 32'h7FC00000);
      chk("hold valid/ready", {30'b0, bus.out_valid, bus.in_ready}, 32'b10);
    end
    release_out();
    chk("release in_ready", 32'(bus.in_ready), 32'd1);

    // reset in the middle of a long alignment
    issue(32'h4B000000, 32'h3F800000, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort result",    bus.result,         32'h0);
    chk("abort flags",     {30'b0, bus.overflow, bus.underflow}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | bus.out_valid;
    end
    chk("abort no out_valid", 32'(seen), 32'd0);
    run("after_reset", 32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
